// File: rtl/rr_mux_pkg.sv
// Shared definitions for the 4:1 round-robin stream merger.
//   NUM_CH / SEL_W : channel count and channel-index width
//   sel_t          : channel index type
//   state_t        : packet-lock FSM states (used only with RR_MUX_PKT_LOCK_EN)
//   onehot()       : channel index -> one-hot channel mask
package rr_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input sel_t idx);
        logic [NUM_CH-1:0] one;
        one = {{(NUM_CH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with its priority pointer.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-channel request
//   advance    : a grant was consumed this cycle
//   lock_en    : the consumed grant is a non-final packet beat; keep the pointer
//   gnt        : one-hot grant (zero when nothing requests)
//   gnt_idx    : index of the granted channel
//   gnt_any    : some channel is granted
module rr_arbiter4
    import rr_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic              lock_en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    sel_t last_grant;

    // Search starts one past the previous winner; the 2-bit add wraps mod 4,
    // so the fourth candidate is the previous winner itself.
    always_comb begin
        sel_t cand;
        gnt_any = 1'b0;
        gnt_idx = last_grant;
        cand    = last_grant;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = last_grant + sel_t'(i);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt = gnt_any ? onehot(gnt_idx) : '0;

    // Pointer moves only on a consumed grant that ends a packet, so idle
    // cycles and mid-packet beats leave priority untouched.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= sel_t'(NUM_CH - 1);
        else if (advance && !lock_en)
            last_grant <= gnt_idx;
    end

endmodule

// File: rtl/rr_mux4x1.sv
// Four-channel to one-channel valid/ready stream merger with round-robin
// arbitration and a single registered output stage carrying the source index.
// Optional packet lock: define RR_MUX_PKT_LOCK_EN to add in_last/out_last and
// hold the grant on one channel until its last beat.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : per-channel valid (bit k = channel k)
//   in_data    : channel k at [k*DATA_W +: DATA_W]
//   in_last    : per-channel end of packet (lock build only)
//   in_ready   : per-channel accept, at most one bit set
//   out_valid  : output register holds a beat
//   out_data   : registered beat
//   out_sel    : channel that produced out_data
//   out_last   : registered end of packet (lock build only)
//   out_ready  : consumer accepts the beat
module rr_mux4x1
    import rr_mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]             req;
    logic [NUM_CH-1:0]             gnt;
    logic [SEL_W-1:0]              gnt_idx;
    logic                          gnt_any;
    logic                          load_en;
    logic                          xfer;
    logic                          lock_en;

    assign ch_data = in_data;

    // The register can take a new beat when empty or being drained this
    // cycle, which gives one beat per cycle under continuous flow.
    assign load_en = !out_valid || out_ready;

    // Gated by rst_n so a reset cycle never signals acceptance.
    assign xfer = rst_n && load_en && gnt_any;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_rdy
            assign in_ready[g] = xfer && gnt[g];
        end
    endgenerate

`ifdef RR_MUX_PKT_LOCK_EN
    state_t state_q, state_d;

    // While locked, out_sel still names the channel that opened the packet,
    // so it doubles as the lock owner.
    assign req     = (state_q == ST_LOCK) ? (in_valid & onehot(out_sel)) : in_valid;
    assign lock_en = !in_last[gnt_idx];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:  if (xfer && !in_last[gnt_idx]) state_d = ST_LOCK;
            ST_LOCK: if (xfer &&  in_last[gnt_idx]) state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_ARB;
        else
            state_q <= state_d;
    end
`else
    assign req     = in_valid;
    assign lock_en = 1'b0;
`endif

    rr_arbiter4 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (xfer),
        .lock_en (lock_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A drain with no refill clears valid only; data and sel keep their values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[gnt_idx];
            out_sel   <= gnt_idx;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last  <= in_last[gnt_idx];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux4x1.sv
// Directed bench for rr_mux4x1: expected beats are queued at each input
// handshake and compared as the consumer takes them.
module tb_rr_mux4x1;
    import rr_mux_pkg::*;

    localparam int DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [3:0]             in_valid;
    logic [4*DATA_W-1:0]    in_data;
    logic [3:0]             in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [1:0]             out_sel;
    logic                   out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
    logic [3:0]             in_last;
    logic                   out_last;
`endif

    int errors = 0;
    int checks = 0;
    logic [DATA_W+1:0] sb[$];

    rr_mux4x1 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] d);
        in_data[k*DATA_W +: DATA_W] = d;
    endtask

    // At the sampling edge, in_ready must be exactly channel k's bit; the
    // beat it accepts at the next rising edge is queued for the consumer.
    task automatic grant(input string tag, input int k, input logic [7:0] d);
        logic [3:0] one;
        one = 4'b0001;
        @(negedge clk);
        check(tag, 32'(in_ready), 32'(one << k));
        sb.push_back({2'(k), d});
    endtask

    // Consumer side: a beat seen with out_valid && out_ready leaves at the
    // next rising edge, so it is popped exactly once.
    always @(negedge clk) begin
        logic [DATA_W+1:0] exp;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'({out_sel, out_data}), 32'h3ff);
            end else begin
                exp = sb.pop_front();
                check("beat", 32'({out_sel, out_data}), 32'(exp));
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = '0;
        for (int k = 0; k < 4; k++) set_ch(k, 8'hA0 + 8'(k));
`ifdef RR_MUX_PKT_LOCK_EN
        in_last   = 4'b1111;
`endif

        // Reset held two edges with every channel requesting.
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_sel",   32'(out_sel),   32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        tick();
        rst_n = 1'b1;

        // Fairness: all valid, full throughput, order 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) begin
            grant("rr_order", i % 4, 8'hA0 + 8'(i % 4));
            tick();
        end
        in_valid = 4'b0000;
        tick();

        // Stall: only channel 2, consumer not ready.
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        set_ch(2, 8'h5C);
        grant("stall_load", 2, 8'h5C);
        tick();
        set_ch(2, 8'h77);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_data",  32'(out_data),  32'h5C);
            check("stall_sel",   32'(out_sel),   32'h2);
            check("stall_ready", 32'(in_ready),  32'h0);
            tick();
        end
        // Release: the held beat drains while the next one loads.
        out_ready = 1'b1;
        grant("drain_load", 2, 8'h77);
        tick();
        in_valid = 4'b0000;
        tick();
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_hold",  32'({out_sel, out_data}), 32'h277);
        tick();

        // Pointer at 1, then channels 0 and 3 together: 3 first, then 0.
        in_valid = 4'b0010;
        set_ch(1, 8'hA1);
        grant("ptr_set1", 1, 8'hA1);
        tick();
        in_valid = 4'b1001;
        set_ch(0, 8'hA0);
        set_ch(3, 8'hA3);
        grant("ptr_pick3", 3, 8'hA3);
        tick();
        in_valid = 4'b0001;
        grant("ptr_pick0", 0, 8'hA0);
        tick();
        in_valid = 4'b0000;

        // Idle for five cycles, then channel 1 alone.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(in_ready), 32'h0);
            tick();
        end
        in_valid = 4'b0010;
        set_ch(1, 8'h11);
        grant("idle_wake", 1, 8'h11);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        check("wake_valid", 32'(out_valid), 32'h1);
        check("wake_sel",   32'(out_sel),   32'h1);
        tick();
        // Pointer stays at 1 through idle cycles: 1 and 2 request -> 2 wins.
        repeat (3) tick();
        in_valid = 4'b0110;
        set_ch(2, 8'h22);
        grant("idle_ptr_hold", 2, 8'h22);
        tick();
        in_valid = 4'b0010;
        grant("idle_ptr_next", 1, 8'h11);
        tick();
        in_valid = 4'b0000;
        tick();

`ifdef RR_MUX_PKT_LOCK_EN
        // Three-beat packet on channel 0 while channel 1 waits.
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        set_ch(0, 8'hB0);
        set_ch(1, 8'hB1);
        grant("pkt_beat1", 0, 8'hB0);
        tick();
        set_ch(0, 8'hB2);
        grant("pkt_beat2", 0, 8'hB2);
        tick();
        set_ch(0, 8'hB4);
        in_last = 4'b0001;
        grant("pkt_beat3", 0, 8'hB4);
        tick();
        in_valid = 4'b0010;
        in_last  = 4'b0010;
        grant("pkt_next", 1, 8'hB1);
        check("pkt_out_last3", 32'(out_last), 32'h1);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        check("pkt_out_last1", 32'(out_last), 32'h1);
        tick();
`endif

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
